abs_neg_pipe: RTL and testbench
===============================

ABS_NEG_PIPE -- requirements
Module: abs_neg_pipe

Interface
REQ-001 SHALL have parameter width, default 8, operand/result word width (>=2).
REQ-002 SHALL have parameter speed, default lau_pkg::FAST, prefix-structure performance selector passed to PrefixAnd.
REQ-003 SHALL have parameter depth, default 2, number of pipeline register stages (1..8).
REQ-004 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port A  input  width  two's-complement operand.
REQ-007 SHALL have port Mode  input  2  operation: 00 pass, 01 abs, 10 negate, 11 negative-abs.
REQ-008 SHALL have port InValid  input  1  A/Mode valid.
REQ-009 SHALL have port InReady  output  1  block accepts A/Mode this cycle.
REQ-010 SHALL have port Z  output  width  result.
REQ-011 SHALL have port V  output  1  overflow: true result not representable in width bits.
REQ-012 SHALL have port OutValid  output  1  Z/V valid.
REQ-013 SHALL have port OutReady  input  1  consumer accepts Z/V.

Function
REQ-014 SHALL compute result combinationally before stage 1 using conditional inversion plus PrefixAnd carry propagation (parallel-prefix complementer), no ripple adder.
REQ-015 Negation enable SHALL be: pass 0; abs A[width-1]; negate 1; negative-abs NOT A[width-1].
REQ-016 V SHALL be 1 only when negation enabled and A = 100..0 (most negative); negate of 0 gives Z=0, V=0; negative-abs never overflows.
REQ-017 Transfer in SHALL occur on a cycle with InValid=1 and InReady=1; transfer out on OutValid=1 and OutReady=1.
REQ-018 Each stage k SHALL hold a valid bit; stage k SHALL load when it is empty or stage k+1 (consumer for last stage) accepts in same cycle.
REQ-019 InReady SHALL equal NOT valid[1] OR ready[2] chained to OutReady (combinational, no bubble); full throughput one result per cycle.
REQ-020 Latency SHALL be exactly depth cycles from input transfer to OutValid with OutReady held 1.
REQ-021 While OutValid=1 and OutReady=0, Z, V, OutValid SHALL stay stable and no stored result SHALL be lost or duplicated.
REQ-022 With all stages full and OutReady=0, InReady SHALL be 0; simultaneous output and input transfer on a full pipe SHALL both complete.
REQ-023 Results SHALL leave in input order; Mode SHALL be sampled per-operand with A.
REQ-024 Empty stages SHALL not update data registers (no toggling on bubbles).

Reset
REQ-025 While RST=1, all valid bits, Z, V SHALL be 0 asynchronously; OutValid=0, InReady=1.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operands; first transfer after release SHALL appear after depth cycles.

Configuration
REQ-027 Macro ABS_NEG_PIPE_SAT_EN defined: on V=1, Z SHALL be saturated to 011..1 (max positive).
REQ-028 Macro ABS_NEG_PIPE_SAT_EN undefined: on V=1, Z SHALL be wrapped result (100..0); V still reported; no saturation logic present.

Verification (width=8, depth=2)
REQ-029 A=0xF6, Mode=01, OutReady=1 -> two cycles later OutValid=1, Z=0x0A, V=0.
REQ-030 A=0x80, Mode=01 -> Z=0x80, V=1 without macro; Z=0x7F, V=1 with ABS_NEG_PIPE_SAT_EN.
REQ-031 Back-to-back A=0x05 (Mode 10), 0x05 (Mode 11), 0x00 (Mode 10), 0x7F (Mode 00) -> Z=0xFB, 0xFB, 0x00, 0x7F in order, one per cycle.
REQ-032 Three inputs, OutReady=0 -> InReady=0 after two accepted, Z holds first result stable; OutReady=1 -> all three drain in order, none lost.
REQ-033 RST pulsed with two operands in flight -> OutValid=0, Z=0, V=0 immediately; no stale output after release.
REQ-034 Random A/Mode/valid/ready streams vs behavioural model -> bit-exact Z, V, order for depth 1 and 8.

Source files
------------

// File: rtl/lau_pkg.sv
// lau_pkg: shared selectors for the arithmetic library blocks.
package lau_pkg;

  // Prefix-network performance selector.
  // FAST  : Kogge-Stone, log2(n) levels, minimum logic depth and fanout.
  // SMALL : Sklansky, log2(n) levels, fewer operators and higher fanout.
  typedef enum logic [0:0] {
    FAST  = 1'b0,
    SMALL = 1'b1
  } speed_t;

endpackage

// File: rtl/abs_neg_pipe.sv
// abs_neg_pipe: pass / abs / negate / negative-abs of a two's-complement word.
// The result is formed combinationally by a parallel-prefix complementer and then
// carried through a depth-stage valid/ready pipeline with full throughput.
// Build option: define ABS_NEG_PIPE_SAT_EN to clamp an overflowed result to the
// maximum positive value; otherwise the wrapped value 100..0 is delivered.
// V flags overflow in both builds.
module abs_neg_pipe #(
  parameter int              width = 8,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST,
  parameter int              depth = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic signed [width-1:0] A,
  input  logic [1:0]              Mode,
  input  logic                    InValid,
  output logic                    InReady,
  output logic signed [width-1:0] Z,
  output logic                    V,
  output logic                    OutValid,
  input  logic                    OutReady
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ABS  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_NABS = 2'b11;

  // Stage 0: combinational complementer.
  // -A = ~A + 1. After conditional inversion x = A ^ {neg}, the carry into bit i is
  // neg AND (x[i-1:0] all ones), so a prefix-AND of x replaces the incrementer.
  logic                    neg_p0;
  logic [width-1:0]        inv_p0;
  logic [width-2:0]        pfx_p0;
  logic [width-1:0]        carry_p0;
  logic signed [width-1:0] zraw_p0;
  logic signed [width-1:0] z_p0;
  logic                    v_p0;

`ifdef ABS_NEG_PIPE_SAT_EN
  // Clamp an overflowed result to 011..1.
  function automatic logic signed [width-1:0] sat_max(
    input logic signed [width-1:0] val,
    input logic                    ovf
  );
    logic signed [width-1:0] res;
    res = val;
    if (ovf) begin
      res = {1'b0, {(width-1){1'b1}}};
    end
    return res;
  endfunction
`endif

  // Decide whether the operand is complemented, from Mode and the operand sign.
  always_comb begin
    neg_p0 = 1'b0;
    case (Mode)
      MODE_PASS: neg_p0 = 1'b0;
      MODE_ABS:  neg_p0 = A[width-1];
      MODE_NEG:  neg_p0 = 1'b1;
      MODE_NABS: neg_p0 = ~A[width-1];
      default:   neg_p0 = 1'b0;
    endcase
  end

  assign inv_p0 = A ^ {width{neg_p0}};

  PrefixAnd #(
    .width (width - 1),
    .speed (speed)
  ) u_pfx (
    .x (inv_p0[width-2:0]),
    .p (pfx_p0)
  );

  assign carry_p0 = {pfx_p0 & {(width-1){neg_p0}}, neg_p0};
  assign zraw_p0  = inv_p0 ^ carry_p0;

  // Only the most negative value overflows: its inverted low bits are all ones and
  // its inverted sign bit is zero. Negating zero inverts the sign bit to one, so it
  // is excluded, and negative-abs never negates a negative operand.
  assign v_p0 = neg_p0 & pfx_p0[width-2] & ~inv_p0[width-1];

`ifdef ABS_NEG_PIPE_SAT_EN
  assign z_p0 = sat_max(zraw_p0, v_p0);
`else
  assign z_p0 = zraw_p0;
`endif

  // Stages 1..depth: valid/ready register chain.
  // A stage loads whenever some stage at or after it is empty or the consumer
  // accepts, which is the chained ~valid | downstream-ready rule written as a
  // reduction so that no signal depends on its own bits.
  logic [depth:1]          vld_pk;
  logic [depth:1]          rdy_pk;
  logic [depth:1]          v_pk;
  logic signed [width-1:0] z_pk [1:depth];

  for (genvar k = 1; k <= depth; k++) begin : g_stage
    logic                    up_vld;
    logic signed [width-1:0] up_z;
    logic                    up_v;

    assign rdy_pk[k] = OutReady | ~(&vld_pk[depth:k]);

    if (k == 1) begin : g_head
      assign up_vld = InValid;
      assign up_z   = z_p0;
      assign up_v   = v_p0;
    end else begin : g_body
      assign up_vld = vld_pk[k-1];
      assign up_z   = z_pk[k-1];
      assign up_v   = v_pk[k-1];
    end

    // Advance the stage when it can accept; data only moves with a valid operand.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        vld_pk[k] <= 1'b0;
        z_pk[k]   <= '0;
        v_pk[k]   <= 1'b0;
      end else if (rdy_pk[k]) begin
        vld_pk[k] <= up_vld;
        if (up_vld) begin
          z_pk[k] <= up_z;
          v_pk[k] <= up_v;
        end
      end
    end
  end

  assign InReady  = rdy_pk[1];
  assign OutValid = vld_pk[depth];
  assign Z        = z_pk[depth];
  assign V        = v_pk[depth];

endmodule

// PrefixAnd: p[i] = &x[i:0], built as a log-depth parallel-prefix network.
module PrefixAnd #(
  parameter int              width = 7,
  parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
  input  logic [width-1:0] x,
  output logic [width-1:0] p
);

  localparam int L = $clog2(width);

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    logic [width-1:0] s;

    if (l == 0) begin : g_in
      assign s = x;
    end else begin : g_op
      localparam int SPAN = 1 << (l - 1);
      for (genvar i = 0; i < width; i++) begin : g_bit
        if (speed == lau_pkg::FAST) begin : g_ks
          if (i >= SPAN) begin : g_mix
            assign s[i] = g_lvl[l-1].s[i] & g_lvl[l-1].s[i-SPAN];
          end else begin : g_pass
            assign s[i] = g_lvl[l-1].s[i];
          end
        end else begin : g_sk
          if (((i / SPAN) % 2) == 1) begin : g_mix
            assign s[i] = g_lvl[l-1].s[i] & g_lvl[l-1].s[(i/(2*SPAN))*(2*SPAN)+SPAN-1];
          end else begin : g_pass
            assign s[i] = g_lvl[l-1].s[i];
          end
        end
      end
    end
  end

  assign p = g_lvl[L].s;

endmodule

// File: tb/tb_abs_neg_pipe.sv
// tb_abs_neg_pipe: directed and randomized checks of abs_neg_pipe at width 8,
// with pipelines of depth 2 (index 0), depth 1 (index 1) and depth 8 (index 2).
module tb_abs_neg_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [1:0] mode;
  logic       in_valid;
  logic       in_ready  [3];
  logic [7:0] z         [3];
  logic       v         [3];
  logic       out_valid [3];
  logic       out_ready [3];

  int n_chk;
  int n_fail;

  // reference scoreboard per pipeline: circular buffers of expected results
  logic [7:0] ez    [3][16];
  logic       ev    [3][16];
  int         pc    [3][16];
  int         head_q[3];
  int         tail_q[3];

  abs_neg_pipe #(.width(8), .depth(2)) u_dut2 (
    .CLK(clk), .RST(rst), .A(a), .Mode(mode), .InValid(in_valid), .InReady(in_ready[0]),
    .Z(z[0]), .V(v[0]), .OutValid(out_valid[0]), .OutReady(out_ready[0]));

  abs_neg_pipe #(.width(8), .depth(1)) u_dut1 (
    .CLK(clk), .RST(rst), .A(a), .Mode(mode), .InValid(in_valid), .InReady(in_ready[1]),
    .Z(z[1]), .V(v[1]), .OutValid(out_valid[1]), .OutReady(out_ready[1]));

  abs_neg_pipe #(.width(8), .depth(8)) u_dut8 (
    .CLK(clk), .RST(rst), .A(a), .Mode(mode), .InValid(in_valid), .InReady(in_ready[2]),
    .Z(z[2]), .V(v[2]), .OutValid(out_valid[2]), .OutReady(out_ready[2]));

  always #5 clk = ~clk;

  // behavioural reference: integer arithmetic on the signed operand value
  function automatic void ref_model(input logic [7:0] a_in, input logic [1:0] m,
                                    output logic [7:0] zr, output logic vr);
    int val;
    int res;
    val = int'($signed(a_in));
    case (m)
      2'd0:    res = val;
      2'd1:    res = (val < 0) ? -val : val;
      2'd2:    res = -val;
      default: res = (val > 0) ? -val : val;
    endcase
    vr = (res > 127) || (res < -128);
`ifdef ABS_NEG_PIPE_SAT_EN
    zr = vr ? 8'h7F : res[7:0];
`else
    zr = res[7:0];
`endif
  endfunction

  // present one operand to the depth-2 pipe, return edges from transfer to OutValid
  // (-1 on timeout); returns at the falling edge where OutValid was seen
  task automatic send_one(input logic [7:0] av, input logic [1:0] mv, output int lat);
    bit acc;
    acc = 1'b0;
    lat = -1;
    a = av; mode = mv; in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (out_valid[0]) begin
          lat = i;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++; if (out_valid[d] !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid dut%0d: got %b, expected 0", d, out_valid[d]); end
      n_chk++; if (z[d] !== 8'h00) begin n_fail++; $display("FAIL reset_z dut%0d: got %h, expected 00", d, z[d]); end
      n_chk++; if (v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_v dut%0d: got %b, expected 0", d, v[d]); end
      n_chk++; if (in_ready[d] !== 1'b1) begin n_fail++; $display("FAIL reset_inready dut%0d: got %b, expected 1", d, in_ready[d]); end
    end
    in_valid = 1'b1;
    a = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_hold_outvalid: got %b, expected 0", out_valid[0]); end
    n_chk++; if (z[0] !== 8'h00) begin n_fail++; $display("FAIL reset_hold_z: got %h, expected 00", z[0]); end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lat;
    send_one(8'hF6, 2'b01, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d, expected 2", lat); end
    n_chk++; if (z[0] !== 8'h0A) begin n_fail++; $display("FAIL single_z: got %h, expected 0a", z[0]); end
    n_chk++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL single_v: got %b, expected 0", v[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [7:0] ta [4];
    logic [1:0] tm [4];
    logic [7:0] tz [4];
    logic       tv [4];
    int lat;
    ta[0] = 8'h80; tm[0] = 2'b01; tv[0] = 1'b1;
`ifdef ABS_NEG_PIPE_SAT_EN
    tz[0] = 8'h7F;
`else
    tz[0] = 8'h80;
`endif
    ta[1] = 8'h00; tm[1] = 2'b10; tz[1] = 8'h00; tv[1] = 1'b0;
    ta[2] = 8'h80; tm[2] = 2'b11; tz[2] = 8'h80; tv[2] = 1'b0;
    ta[3] = 8'h7F; tm[3] = 2'b10; tz[3] = 8'h81; tv[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_one(ta[i], tm[i], lat);
      n_chk++; if (z[0] !== tz[i]) begin n_fail++; $display("FAIL edge_z[%0d]: got %h, expected %h", i, z[0], tz[i]); end
      n_chk++; if (v[0] !== tv[i]) begin n_fail++; $display("FAIL edge_v[%0d]: got %b, expected %b", i, v[0], tv[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4];
    logic [1:0] tm [4];
    logic [7:0] tz [4];
    bit exp_ov;
    ta[0] = 8'h05; tm[0] = 2'b10; tz[0] = 8'hFB;
    ta[1] = 8'h05; tm[1] = 2'b11; tz[1] = 8'hFB;
    ta[2] = 8'h00; tm[2] = 2'b10; tz[2] = 8'h00;
    ta[3] = 8'h7F; tm[3] = 2'b00; tz[3] = 8'h7F;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin a = ta[k]; mode = tm[k]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (k < 4) begin
        n_chk++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_inready[%0d]: got %b, expected 1", k, in_ready[0]); end
      end
      exp_ov = (k >= 2) && (k <= 5);
      n_chk++; if (out_valid[0] !== exp_ov) begin n_fail++; $display("FAIL b2b_outvalid[%0d]: got %b, expected %b", k, out_valid[0], exp_ov); end
      if (exp_ov) begin
        n_chk++; if (z[0] !== tz[k-2]) begin n_fail++; $display("FAIL b2b_z[%0d]: got %h, expected %h", k, z[0], tz[k-2]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba [3];
    logic [1:0] bm [3];
    logic [7:0] bz [3];
    int idx;
    int got;
    ba[0] = 8'h11; bm[0] = 2'b10; bz[0] = 8'hEF;
    ba[1] = 8'h90; bm[1] = 2'b01; bz[1] = 8'h70;
    ba[2] = 8'h03; bm[2] = 2'b11; bz[2] = 8'hFD;
    idx = 0;
    out_ready[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a = ba[idx]; mode = bm[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (k >= 2) begin
        n_chk++; if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL stall_inready[%0d]: got %b, expected 0", k, in_ready[0]); end
        n_chk++; if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL stall_outvalid[%0d]: got %b, expected 1", k, out_valid[0]); end
        n_chk++; if (z[0] !== bz[0]) begin n_fail++; $display("FAIL stall_z[%0d]: got %h, expected %h", k, z[0], bz[0]); end
        n_chk++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL stall_v[%0d]: got %b, expected 0", k, v[0]); end
      end
      if (in_ready[0] && idx < 2) idx++;
      @(posedge clk); #1;
    end
    n_chk++; if (idx !== 2) begin n_fail++; $display("FAIL stall_accepted: got %0d, expected 2", idx); end
    out_ready[0] = 1'b1;
    got = 0;
    for (int k = 0; k < 15 && got < 3; k++) begin
      if (idx < 3) begin a = ba[idx]; mode = bm[idx]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL drain_simul_inready: got %b, expected 1", in_ready[0]); end
      end
      if (out_valid[0]) begin
        n_chk++; if (z[0] !== bz[got]) begin n_fail++; $display("FAIL drain_z[%0d]: got %h, expected %h", got, z[0], bz[got]); end
        got++;
      end
      if (in_valid && in_ready[0]) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_chk++; if (got !== 3) begin n_fail++; $display("FAIL drain_count: got %0d, expected 3", got); end
  endtask

  task automatic test_reset_midflight();
    int lat;
    out_ready[0] = 1'b0;
    a = 8'h33; mode = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_inready0: got %b, expected 1", in_ready[0]); end
    @(posedge clk); #1;
    a = 8'h44; mode = 2'b10;
    @(negedge clk);
    n_chk++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_inready1: got %b, expected 1", in_ready[0]); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (z[0] !== 8'h33) begin n_fail++; $display("FAIL mid_before_z: got %h, expected 33", z[0]); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outvalid: got %b, expected 0", out_valid[0]); end
    n_chk++; if (z[0] !== 8'h00) begin n_fail++; $display("FAIL mid_rst_z: got %h, expected 00", z[0]); end
    n_chk++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_v: got %b, expected 0", v[0]); end
    n_chk++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_rst_inready: got %b, expected 1", in_ready[0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++; if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %b, expected 0", k, out_valid[0]); end
      @(posedge clk); #1;
    end
    send_one(8'h05, 2'b10, lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL mid_after_latency: got %0d, expected 2", lat); end
    n_chk++; if (z[0] !== 8'hFB) begin n_fail++; $display("FAIL mid_after_z: got %h, expected fb", z[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int dep [3];
    int cyc;
    int cnt;
    int slot;
    bit exp_ir;
    bit exp_ov;
    logic [7:0] rz;
    logic       rv;
    dep[0] = 2; dep[1] = 1; dep[2] = 8;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin head_q[d] = 0; tail_q[d] = 0; end
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 8'h80;
        1:       a = 8'h00;
        default: a = 8'($urandom_range(0, 255));
      endcase
      mode = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 9) < 7);
      for (int d = 0; d < 3; d++) begin
        if (((n / 200) % 2) == 1) out_ready[d] = ($urandom_range(0, 3) == 0);
        else out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        cnt = tail_q[d] - head_q[d];
        slot = head_q[d] % 16;
        exp_ir = (cnt < dep[d]) || out_ready[d];
        exp_ov = (cnt > 0) && ((cyc - pc[d][slot]) >= dep[d]);
        n_chk++; if (in_ready[d] !== exp_ir) begin n_fail++; $display("FAIL rand_inready dut%0d cyc%0d: got %b, expected %b", d, cyc, in_ready[d], exp_ir); end
        n_chk++; if (out_valid[d] !== exp_ov) begin n_fail++; $display("FAIL rand_outvalid dut%0d cyc%0d: got %b, expected %b", d, cyc, out_valid[d], exp_ov); end
        if (exp_ov && out_valid[d]) begin
          n_chk++; if (z[d] !== ez[d][slot]) begin n_fail++; $display("FAIL rand_z dut%0d cyc%0d: got %h, expected %h", d, cyc, z[d], ez[d][slot]); end
          n_chk++; if (v[d] !== ev[d][slot]) begin n_fail++; $display("FAIL rand_v dut%0d cyc%0d: got %b, expected %b", d, cyc, v[d], ev[d][slot]); end
        end
        if (out_valid[d] && out_ready[d] && cnt > 0) head_q[d]++;
        if (in_valid && in_ready[d]) begin
          ref_model(a, mode, rz, rv);
          ez[d][tail_q[d] % 16] = rz;
          ev[d][tail_q[d] % 16] = rv;
          pc[d][tail_q[d] % 16] = cyc;
          tail_q[d]++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    a = 8'h00;
    mode = 2'b00;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) out_ready[d] = 1'b1;
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
